// File: rtl/regfile_pkg.sv
// Shared defaults and constants for the multi-port bypassing register file.
// Imported by the top and by the staging sub-module.
package regfile_pkg;
    localparam int DEF_WIDTH  = 16;
    localparam int DEF_NREGS  = 8;
    localparam int DEF_NREAD  = 2;
    localparam int DEF_NWRITE = 2;
    localparam int CNT_W      = 8;
endpackage

// File: rtl/regfile_wstage.sv
// One write port's staging entry: captures a write at edge N
// so the array can absorb it at edge N+1.
module regfile_wstage
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [SEL_W-1:0] load_sel,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] data
);
    // A port idle for a cycle drops its entry; the previous one has already been committed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            sel   <= '0;
            data  <= '0;
        end else begin
            valid <= load_en;
            if (load_en) begin
                sel  <= load_sel;
                data <= load_data;
            end
        end
    end
endmodule

// File: rtl/regfile_mp_bypass.sv
// Multi-port register file with optional one-cycle staged writes and full
// read bypass (current writes, then staged writes, then the array).
module regfile_mp_bypass
    import regfile_pkg::*;
#(
    parameter int  WIDTH  = DEF_WIDTH,
    parameter int  NREGS  = DEF_NREGS,
    parameter int  NREAD  = DEF_NREAD,
    parameter int  NWRITE = DEF_NWRITE,
    parameter int  STAGED = 1,
    localparam int SEL_W  = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*SEL_W-1:0]  readRegSel,
    output logic [NREAD*WIDTH-1:0]  readData,
    input  logic [NWRITE*SEL_W-1:0] writeRegSel,
    input  logic [NWRITE*WIDTH-1:0] writeData,
    input  logic [NWRITE-1:0]       writeEn,
    output logic                    err,
    output logic [CNT_W-1:0]        conflictCnt
);
    logic [WIDTH-1:0] mem_reg [NREGS];

    logic [SEL_W-1:0] wr_sel   [NWRITE];
    logic [WIDTH-1:0] wr_data  [NWRITE];
    logic             stg_valid [NWRITE];
    logic [SEL_W-1:0] stg_sel  [NWRITE];
    logic [WIDTH-1:0] stg_data [NWRITE];
    logic             cm_en    [NWRITE];
    logic [SEL_W-1:0] cm_sel   [NWRITE];
    logic [WIDTH-1:0] cm_data  [NWRITE];
    logic             conflict;

    generate
        for (genvar gi = 0; gi < NWRITE; gi++) begin : g_wport
            assign wr_sel[gi]  = writeRegSel[gi*SEL_W +: SEL_W];
            assign wr_data[gi] = writeData[gi*WIDTH +: WIDTH];
        end

        if (STAGED != 0) begin : g_staged
            for (genvar gi = 0; gi < NWRITE; gi++) begin : g_stage
                regfile_wstage #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_wstage (
                    .clk       (clk),
                    .rst       (rst),
                    .load_en   (writeEn[gi]),
                    .load_sel  (wr_sel[gi]),
                    .load_data (wr_data[gi]),
                    .valid     (stg_valid[gi]),
                    .sel       (stg_sel[gi]),
                    .data      (stg_data[gi])
                );
                assign cm_en[gi]   = stg_valid[gi];
                assign cm_sel[gi]  = stg_sel[gi];
                assign cm_data[gi] = stg_data[gi];
            end
        end else begin : g_direct
            for (genvar gi = 0; gi < NWRITE; gi++) begin : g_nostage
                assign stg_valid[gi] = 1'b0;
                assign stg_sel[gi]   = '0;
                assign stg_data[gi]  = '0;
                assign cm_en[gi]     = writeEn[gi];
                assign cm_sel[gi]    = wr_sel[gi];
                assign cm_data[gi]   = wr_data[gi];
            end
        end
    endgenerate

    // Ascending port order: the highest-index port's assignment lands last and wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) mem_reg[r] <= '0;
        end else begin
            for (int w = 0; w < NWRITE; w++) begin
                if (cm_en[w]) mem_reg[cm_sel[w]] <= cm_data[w];
            end
        end
    end

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < NWRITE; i++) begin
            for (int j = i + 1; j < NWRITE; j++) begin
                if (writeEn[i] && writeEn[j] && (wr_sel[i] == wr_sel[j])) conflict = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err         <= 1'b0;
            conflictCnt <= '0;
        end else if (conflict) begin
            err <= 1'b1;
            if (conflictCnt != {CNT_W{1'b1}}) conflictCnt <= conflictCnt + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NREAD; gi++) begin : g_rport
            logic [SEL_W-1:0] rd_sel;
            logic [WIDTH-1:0] rd_val;

            assign rd_sel = readRegSel[gi*SEL_W +: SEL_W];

            // Later matches override earlier ones, giving current writes over staged over array.
            always_comb begin
                rd_val = mem_reg[rd_sel];
                for (int w = 0; w < NWRITE; w++) begin
                    if (stg_valid[w] && (stg_sel[w] == rd_sel)) rd_val = stg_data[w];
                end
                for (int w = 0; w < NWRITE; w++) begin
                    if (writeEn[w] && (wr_sel[w] == rd_sel)) rd_val = wr_data[w];
                end
            end

            assign readData[gi*WIDTH +: WIDTH] = rd_val;
        end
    endgenerate
endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Self-checking bench: architectural model where every write is visible at once
// in port order, so staging must be invisible to readers.
module tb_regfile_mp_bypass;
    logic        clk;
    logic        rst;
    logic [5:0]  readRegSel;
    logic [31:0] readData;
    logic [5:0]  writeRegSel;
    logic [31:0] writeData;
    logic [1:0]  writeEn;
    logic        err;
    logic [7:0]  conflictCnt;

    int          tests;
    int          fails;
    logic [15:0] mdl [8];
    logic        mdl_err;
    int          mdl_cnt;

    regfile_mp_bypass #(
        .WIDTH(16), .NREGS(8), .NREAD(2), .NWRITE(2), .STAGED(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .readRegSel  (readRegSel),
        .readData    (readData),
        .writeRegSel (writeRegSel),
        .writeData   (writeData),
        .writeEn     (writeEn),
        .err         (err),
        .conflictCnt (conflictCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_status();
        tests++;
        assert (err === mdl_err) else begin
            fails++;
            $error("FAIL err observed=%b expected=%b", err, mdl_err);
        end
        tests++;
        assert (conflictCnt === 8'(mdl_cnt)) else begin
            fails++;
            $error("FAIL conflictCnt observed=%0d expected=%0d", conflictCnt, mdl_cnt);
        end
    endtask

    // Drive one cycle, check reads before the edge and status after it.
    task automatic cycle(input logic [1:0] we, input logic [2:0] ws0, input logic [2:0] ws1,
                         input logic [15:0] wd0, input logic [15:0] wd1,
                         input logic [2:0] rs0, input logic [2:0] rs1);
        logic [15:0] nxt [8];
        writeEn     = we;
        writeRegSel = {ws1, ws0};
        writeData   = {wd1, wd0};
        readRegSel  = {rs1, rs0};
        #2;
        nxt = mdl;
        if (we[0]) nxt[ws0] = wd0;
        if (we[1]) nxt[ws1] = wd1;
        check16("read0", readData[15:0], nxt[rs0]);
        check16("read1", readData[31:16], nxt[rs1]);
        $display("[TB] t=%0t we=%b w0=r%0d:%h w1=r%0d:%h rd r%0d=%h r%0d=%h err=%b cnt=%0d",
                 $time, we, ws0, wd0, ws1, wd1, rs0, readData[15:0], rs1, readData[31:16],
                 err, conflictCnt);
        @(posedge clk);
        #1;
        mdl = nxt;
        if (we == 2'b11 && ws0 == ws1) begin
            mdl_err = 1'b1;
            if (mdl_cnt < 255) mdl_cnt++;
        end
        check_status();
    endtask

    // Asserted between edges; clears must be visible without a clock edge.
    task automatic do_reset();
        writeEn = 2'b00;
        rst = 1'b0;
        #1;
        for (int r = 0; r < 8; r++) mdl[r] = '0;
        mdl_err = 1'b0;
        mdl_cnt = 0;
        readRegSel = {3'd7, 3'd0};
        #1;
        check16("rst_read0", readData[15:0], 16'h0000);
        check16("rst_read1", readData[31:16], 16'h0000);
        check_status();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        writeEn = '0; writeRegSel = '0; writeData = '0; readRegSel = '0;
        rst = 1'b0;
        #3;
        do_reset();

        // Scenario 1: every register reads zero after reset
        for (int r = 0; r < 8; r += 2) cycle(2'b00, 0, 0, 0, 0, 3'(r), 3'(r + 1));

        // Scenario 2: write-through, then staged, then array
        cycle(2'b01, 3, 0, 16'h1234, 0, 3, 3);
        check16("s2_wt", readData[15:0], 16'h1234);
        cycle(2'b00, 0, 0, 0, 0, 3, 0);
        cycle(2'b00, 0, 0, 0, 0, 3, 1);

        // Scenario 3: conflict, port1 wins
        cycle(2'b11, 5, 5, 16'hAAAA, 16'h5555, 5, 5);
        check16("s3_cnt", {8'h00, conflictCnt}, 16'h0001);
        cycle(2'b00, 0, 0, 0, 0, 5, 5);
        cycle(2'b00, 0, 0, 0, 0, 5, 4);

        // Scenario 4: back-to-back writes to r2 keep the newer value
        cycle(2'b01, 2, 0, 16'h0001, 0, 2, 2);
        cycle(2'b10, 0, 2, 0, 16'h0002, 2, 2);
        cycle(2'b00, 0, 0, 0, 0, 2, 2);
        cycle(2'b00, 0, 0, 0, 0, 2, 2);

        // Scenario 5: staged write discarded by reset
        cycle(2'b01, 7, 0, 16'hBEEF, 0, 7, 7);
        do_reset();
        cycle(2'b00, 0, 0, 0, 0, 7, 7);
        cycle(2'b00, 0, 0, 0, 0, 7, 3);

        // Scenario 6: counter saturation
        for (int i = 0; i < 300; i++)
            cycle(2'b11, 3'(i), 3'(i), 16'(i), 16'(~i), 3'(i), 3'(i + 1));
        check16("s6_cnt", {8'h00, conflictCnt}, 16'h00FF);

        // Randomised traffic on a narrow register window to force overlaps
        do_reset();
        for (int i = 0; i < 400; i++)
            cycle(2'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                  16'($urandom), 16'($urandom),
                  3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_mp_bypass.md
REGFILE_MP_BYPASS -- requirements
Module: regfile_mp_bypass

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data width of each register in bits.
REQ-002 Parameter NREGS, default 8, SHALL set the register count and SHALL be a power of two, at least 2.
REQ-003 Parameter NREAD, default 2, SHALL set the number of read ports.
REQ-004 Parameter NWRITE, default 2, SHALL set the number of write ports.
REQ-005 Parameter STAGED, default 1, SHALL select the write path: 0 is a direct write, 1 is a one-cycle staged write.
REQ-006 SEL_W SHALL be derived as log2(NREGS).
REQ-007 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-008 rst  in  1  SHALL be reset, asynchronous and active-low.
REQ-009 readRegSel  in  NREAD*SEL_W  SHALL carry the packed read selects; port i uses slice i.
REQ-010 readData  out  NREAD*WIDTH  SHALL carry the packed read data; port i uses slice i.
REQ-011 writeRegSel  in  NWRITE*SEL_W  SHALL carry the packed write selects.
REQ-012 writeData  in  NWRITE*WIDTH  SHALL carry the packed write data.
REQ-013 writeEn  in  NWRITE  SHALL carry one write enable per write port.
REQ-014 err  out  1  SHALL be a sticky write-conflict flag.
REQ-015 conflictCnt  out  8  SHALL be a saturating count of cycles that had a write conflict.

Function
REQ-016 The array SHALL hold NREGS x WIDTH bits.
REQ-017 With STAGED=0, an enabled write SHALL update the array at the same rising edge.
REQ-018 With STAGED=1, each write port SHALL have a staging entry (valid, sel, data).
- The staging entry SHALL load at edge N.
- The array SHALL take the staged value at edge N+1.
REQ-019 A staged entry whose port has writeEn low at an edge SHALL clear its valid bit at that edge.
REQ-020 Read data SHALL be combinational with zero-cycle latency and no internal read state.
REQ-021 Each read port SHALL resolve in this priority order:
- (a) current-cycle enabled writes matching its select, highest port index first;
- (b) valid staged entries matching its select, highest port index first;
- (c) the array.
REQ-022 A conflict SHALL be two or more enabled write ports with equal select in one cycle.
- On a conflict the highest index port SHALL win for both the commit and the bypass.
REQ-023 Staged-entry conflicts SHALL resolve identically: the highest index wins the commit.
REQ-024 A current-cycle write and an older staged write to the same register SHALL commit in order, so the newer value remains.
REQ-025 err SHALL rise at the edge following the first conflict and hold until reset.
REQ-026 conflictCnt SHALL increment by one at each edge following a conflict cycle, saturating at 255.
REQ-027 A read and a write to the same register in one cycle SHALL return the new write data (write-through).

Reset
REQ-028 Asserting rst low SHALL immediately clear all registers to 0, all staging valid bits, err and conflictCnt, independent of clk.
REQ-029 Staged writes pending at reset SHALL be discarded and never committed.
REQ-030 The block SHALL accept writes at the first rising edge after rst deasserts.

Structure
REQ-031 A shared package regfile_pkg SHALL hold the default WIDTH/NREGS/NREAD/NWRITE values and the CNT_W=8 constant.
REQ-032 One sub-module, regfile_wstage, SHALL implement a single write port's staging entry, instantiated NWRITE times when STAGED=1.
REQ-033 The bypass priority mux SHALL be generated per read port inside regfile_mp_bypass.

Verification
REQ-034 Scenario 1: reset, then read all registers -> all 0, err=0, conflictCnt=0.
REQ-035 Scenario 2: STAGED=1, write port0 r3=0x1234 with read r3 in the same cycle -> 0x1234.
- Next cycle, writeEn low, read r3 -> 0x1234 via the staged entry.
- The cycle after -> 0x1234 from the array.
REQ-036 Scenario 3: port0 r5=0xAAAA and port1 r5=0x5555 in one cycle -> read r5 gives 0x5555.
- err=1 from the next edge.
- conflictCnt=1.
REQ-037 Scenario 4: r2=0x0001 at cycle N, r2=0x0002 at cycle N+1 -> read r2 gives 0x0002 at N+1, N+2 and N+3.
REQ-038 Scenario 5: write r7=0xBEEF, assert rst before commit -> after release, r7 reads 0.
REQ-039 Scenario 6: 300 consecutive conflict cycles -> conflictCnt=255 and err=1.
